prim_clock_div_mux: RTL and testbench

Parametrised divided-clock selector for clock-control subsystems. From one source clock it derives NumSel power-of-two divided clocks and drives one of them on a registered output. Select changes go through a request/acknowledge handshake and take effect only at a common low boundary. A glitch-free enable gate is included, so the output never shows a runt pulse or a truncated phase.

---
 rtl/prim_clock_div_mux.sv | 108 ++++++++++
 tb/tb_prim_clock_div_mux.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/prim_clock_div_mux.sv
// Divided-clock selector: a free-running counter provides power-of-two clocks, one of
// which is gated and registered onto clk_o; select changes are deferred to a common wrap.
module prim_clock_div_mux #(
    parameter int NumSel     = 4,
    parameter int DefaultSel = 0,
    parameter int SelW       = $clog2(NumSel)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            sel_req_i,
    input  logic [SelW-1:0] sel_i,
    input  logic            en_i,
    output logic            clk_o,
    output logic [SelW-1:0] sel_o,
    output logic            busy_o,
    output logic            sel_ack_o,
    output logic            err_o
);

    localparam logic [NumSel-1:0] CntOnes  = {NumSel{1'b1}};
    localparam logic [SelW-1:0]   DefSel   = SelW'(DefaultSel);
    localparam logic [SelW:0]     SelLimit = (SelW+1)'(NumSel);

    logic [NumSel-1:0] cnt_r;
    logic [SelW-1:0]   sel_r;
    logic [SelW-1:0]   pend_r;
    logic              busy_r;
    logic              ack_r;
    logic              err_r;
    logic              gate_r;
    logic              clk_r;

    logic [NumSel-1:0] cnt_nxt_s;
    logic              wrap_s;
    logic              switch_s;
    logic              accept_s;
    logic              drop_s;
    logic [SelW-1:0]   sel_nxt_s;
    logic              next_bit_s;
    logic              gate_nxt_s;

    // Next-state decode: counter, request qualification, switch point and gate update.
    always_comb begin
        cnt_nxt_s  = cnt_r + NumSel'(1);
        wrap_s     = (cnt_r == CntOnes);
        switch_s   = wrap_s & busy_r;
        accept_s   = 1'b0;
        drop_s     = 1'b0;
        if (sel_req_i) begin
            if (!busy_r && ({1'b0, sel_i} < SelLimit)) begin
                accept_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
        end
        if (switch_s) begin
            sel_nxt_s = pend_r;
        end else begin
            sel_nxt_s = sel_r;
        end
        next_bit_s = cnt_nxt_s[sel_nxt_s];
        // The enable is only sampled while the next output level is low, so a phase is never cut.
        if (next_bit_s) begin
            gate_nxt_s = gate_r;
        end else begin
            gate_nxt_s = en_i;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r  <= '0;
            sel_r  <= DefSel;
            pend_r <= DefSel;
            busy_r <= 1'b0;
            ack_r  <= 1'b0;
            err_r  <= 1'b0;
            gate_r <= 1'b0;
            clk_r  <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            sel_r  <= sel_nxt_s;
            gate_r <= gate_nxt_s;
            clk_r  <= gate_nxt_s & next_bit_s;
            ack_r  <= switch_s;
            err_r  <= drop_s;
            // Accept and switch are exclusive: accept needs idle, switch needs busy.
            if (accept_s) begin
                pend_r <= sel_i;
                busy_r <= 1'b1;
            end else if (switch_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    assign clk_o     = clk_r;
    assign sel_o     = sel_r;
    assign busy_o    = busy_r;
    assign sel_ack_o = ack_r;
    assign err_o     = err_r;

endmodule

// File: tb/tb_prim_clock_div_mux.sv
// Directed bench: a vector table for a NumSel=4 instance plus hand sequences for
// reset during a pending switch and range checking on a NumSel=6 instance.
module tb_prim_clock_div_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, req_a, en_a;
    logic [1:0] sel_a;
    logic       clk_oa, busy_a, ack_a, err_a;
    logic [1:0] selo_a;

    logic       rst_b, req_b, en_b;
    logic [2:0] sel_b;
    logic       clk_ob, busy_b, ack_b, err_b;
    logic [2:0] selo_b;

    prim_clock_div_mux #(.NumSel(4), .DefaultSel(0)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .sel_req_i(req_a), .sel_i(sel_a), .en_i(en_a),
        .clk_o(clk_oa), .sel_o(selo_a), .busy_o(busy_a), .sel_ack_o(ack_a), .err_o(err_a)
    );

    prim_clock_div_mux #(.NumSel(6), .DefaultSel(1)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .sel_req_i(req_b), .sel_i(sel_b), .en_i(en_b),
        .clk_o(clk_ob), .sel_o(selo_b), .busy_o(busy_b), .sel_ack_o(ack_b), .err_o(err_b)
    );

    typedef struct {
        logic       rst;
        logic       req;
        logic [1:0] sel;
        logic       en;
        logic       clk;
        logic [1:0] sel_o;
        logic       busy;
        logic       ack;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(input logic r, input logic q, input logic [1:0] s, input logic e,
                                input logic c, input logic [1:0] so, input logic b,
                                input logic a, input logic er);
        vec_t v;
        v.rst = r; v.req = q; v.sel = s; v.en = e;
        v.clk = c; v.sel_o = so; v.busy = b; v.ack = a; v.err = er;
        vecs.push_back(v);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int   n;
        logic found;
        int   ackc;

        rst_a = 1'b1; req_a = 1'b0; sel_a = 2'd0; en_a = 1'b1;
        rst_b = 1'b1; req_b = 1'b0; sel_b = 3'd0; en_b = 1'b1;

        // reset held three cycles
        repeat (3) add(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        // start-up at /2: gate opens at cnt 2, first high at cnt 3
        add(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        // request /16 at cnt 5
        add(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        // pending; a request for select 1 at cnt 9 is dropped
        for (int k = 7; k <= 15; k++)
            add(1'b0, k == 10, (k == 10) ? 2'd1 : 2'd0, 1'b1, (k % 2) == 1, 2'd0, 1'b1, 1'b0, k == 10);
        // switch at the wrap: ack, select 3, low output
        add(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 15; k++)
            add(1'b0, 1'b0, 2'd0, 1'b1, k >= 8, 2'd3, 1'b0, 1'b0, 1'b0);
        // request select 2 in a wrap cycle while idle: switches one full period later
        add(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++)
            add(1'b0, 1'b0, 2'd0, 1'b1, k >= 8, 2'd3, 1'b1, 1'b0, 1'b0);
        // request in the switch cycle is dropped while the switch completes
        add(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1);
        // /8 with en dropped mid high phase, raised mid low phase
        for (int k = 51; k <= 81; k++)
            add(1'b0, 1'b0, 2'd0, !(k >= 55 && k <= 66),
                (k >= 54 && k <= 57) || (k >= 70 && k <= 73) || (k >= 78 && k <= 81),
                2'd2, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_a = vecs[i].rst; req_a = vecs[i].req; sel_a = vecs[i].sel; en_a = vecs[i].en;
            tick();
            check($sformatf("vec%0d {clk,sel,busy,ack,err}", i),
                  32'({clk_oa, selo_a, busy_a, ack_a, err_a}),
                  32'({vecs[i].clk, vecs[i].sel_o, vecs[i].busy, vecs[i].ack, vecs[i].err}));
        end

        // reset while a switch is pending
        req_a = 1'b1; sel_a = 2'd1;
        tick();
        check("midsw_busy", 32'(busy_a), 32'd1);
        req_a = 1'b0;
        repeat (3) tick();
        rst_a = 1'b1;
        tick();
        check("midsw_rst_sel", 32'(selo_a), 32'd0);
        check("midsw_rst_busy", 32'(busy_a), 32'd0);
        check("midsw_rst_ack", 32'(ack_a), 32'd0);
        check("midsw_rst_clk", 32'(clk_oa), 32'd0);
        rst_a = 1'b0;
        tick(); check("midsw_clk1", 32'(clk_oa), 32'd0);
        tick(); check("midsw_clk2", 32'(clk_oa), 32'd0);
        tick(); check("midsw_clk3", 32'(clk_oa), 32'd1);
        tick(); check("midsw_clk4", 32'(clk_oa), 32'd0);
        ackc = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ack_a === 1'b1 || busy_a === 1'b1) ackc++;
        end
        check("midsw_no_ack", 32'(ackc), 32'd0);

        // NumSel=6 instance: reset state and range checks
        check("b_rst_sel", 32'(selo_b), 32'd1);
        check("b_rst_flags", 32'({clk_ob, busy_b, ack_b, err_b}), 32'd0);
        rst_b = 1'b0;
        tick();
        req_b = 1'b1; sel_b = 3'd7;
        tick();
        check("b_oor7_err", 32'(err_b), 32'd1);
        check("b_oor7_state", 32'({busy_b, selo_b}), 32'({1'b0, 3'd1}));
        req_b = 1'b0;
        tick();
        check("b_err_oneshot", 32'(err_b), 32'd0);
        req_b = 1'b1; sel_b = 3'd6;
        tick();
        check("b_oor6_err", 32'({err_b, busy_b}), 32'({1'b1, 1'b0}));
        sel_b = 3'd5;
        tick();
        check("b_acc5", 32'({err_b, busy_b}), 32'({1'b0, 1'b1}));
        sel_b = 3'd2;
        tick();
        check("b_busy_drop", 32'({err_b, busy_b}), 32'({1'b1, 1'b1}));
        req_b = 1'b0;
        n = 0; found = 1'b0;
        while (n < 80 && !found) begin
            tick();
            n++;
            if (ack_b === 1'b1) found = 1'b1;
        end
        check("b_ack_latency", 32'(n), 32'd58);
        check("b_new_sel", 32'({busy_b, selo_b}), 32'({1'b0, 3'd5}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
